rgb_layer_compositor: RTL

//  Parametrised, pipelined RGB compositor for the VGA output path: merges NUM_LAYERS

---
 rtl/vga_pkg.sv | 15 +
 rtl/rgb_layer_compositor_if.sv | 37 +++
 rtl/layer_priority_enc.sv | 22 ++
 rtl/rgb_layer_compositor.sv | 95 +++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA pixel-path constants: pixel word width, default transparency key and
// channel slot positions, reused by the sprite/background generators and the compositor.
package vga_pkg;
    localparam int DEF_CH_W = 3;
    localparam logic [8:0] DEF_KEY_COLOR = 9'b111111110;

    // Channel position inside a {B,G,R} pixel word, in units of CH_W.
    localparam int R_SLOT = 0;
    localparam int G_SLOT = 1;
    localparam int B_SLOT = 2;

    function automatic int pix_w(input int ch_w);
        return 3 * ch_w;
    endfunction
endpackage

// File: rtl/rgb_layer_compositor_if.sv
// Pixel-source to DAC bundle for the layer compositor: layer inputs, strobes and
// composited colour / overlap-counter outputs.
interface rgb_layer_compositor_if
    import vga_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int CH_W       = DEF_CH_W,
    parameter int CNT_W      = 16
);
    localparam int PIX_W = pix_w(CH_W);

    logic                        pix_en;
    logic                        active_area;
    logic                        frame_start;
    logic [NUM_LAYERS*PIX_W-1:0] layer_data;
    logic [NUM_LAYERS-1:0]       layer_hit;
    logic [NUM_LAYERS-1:0]       layer_enable;
    logic [PIX_W-1:0]            base_background;
    logic [CH_W-1:0]             out_R;
    logic [CH_W-1:0]             out_G;
    logic [CH_W-1:0]             out_B;
    logic                        out_active;
    logic [CNT_W-1:0]            coll_count;
    logic                        coll_irq;

    modport master (
        output pix_en, active_area, frame_start, layer_data, layer_hit, layer_enable,
               base_background,
        input  out_R, out_G, out_B, out_active, coll_count, coll_irq
    );

    modport slave (
        input  pix_en, active_area, frame_start, layer_data, layer_hit, layer_enable,
               base_background,
        output out_R, out_G, out_B, out_active, coll_count, coll_irq
    );
endinterface

// File: rtl/layer_priority_enc.sv
// Lowest-index-first priority encoder: returns the index of the first asserted request
// plus a flag saying whether any request is asserted.
module layer_priority_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        // Scan high to low so the lowest asserted index is written last and wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rgb_layer_compositor.sv
// Two-stage RGB layer compositor with transparency key, per-layer enables and a
// per-frame saturating overlap counter between layers COLL_A and COLL_B.
module rgb_layer_compositor
    import vga_pkg::*;
#(
    parameter int                NUM_LAYERS = 4,
    parameter int                CH_W       = DEF_CH_W,
    parameter logic [3*CH_W-1:0] KEY_COLOR  = DEF_KEY_COLOR,
    parameter int                COLL_A     = 0,
    parameter int                COLL_B     = 1,
    parameter int                CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    rgb_layer_compositor_if.slave bus
);
    localparam int PIX_W = pix_w(CH_W);
    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    typedef struct packed {
        logic             any;
        logic             active;
        logic [PIX_W-1:0] win_pix;
        logic [PIX_W-1:0] base;
    } s1_t;

    logic [NUM_LAYERS-1:0][PIX_W-1:0] layer_pix;
    logic [NUM_LAYERS-1:0]            opaque;
    logic [IDX_W-1:0]                 win_idx;
    logic                             any_opq;
    s1_t                              s1_q;
    logic [PIX_W-1:0]                 out_pix_q;
    logic                             out_active_q;
    logic                             ovl;
    logic [CNT_W-1:0]                 cnt_q;
    logic [CNT_W-1:0]                 coll_count_q;
    logic                             coll_irq_q;

    assign layer_pix = bus.layer_data;

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_opq
        assign opaque[i] = bus.layer_hit[i] & bus.layer_enable[i] & (layer_pix[i] != KEY_COLOR);
    end

    layer_priority_enc #(.N(NUM_LAYERS), .IDX_W(IDX_W)) u_enc (
        .req (opaque),
        .idx (win_idx),
        .any (any_opq)
    );

    // Both stages move together on pix_en so a stalled strobe never creates a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q         <= '0;
            out_pix_q    <= '0;
            out_active_q <= 1'b0;
        end else if (bus.pix_en) begin
            s1_q.any     <= any_opq;
            s1_q.active  <= bus.active_area;
            s1_q.win_pix <= layer_pix[win_idx];
            s1_q.base    <= bus.base_background;
            out_pix_q    <= !s1_q.active ? '0 : (s1_q.any ? s1_q.win_pix : s1_q.base);
            out_active_q <= s1_q.active;
        end
    end

    assign bus.out_R      = out_pix_q[R_SLOT*CH_W +: CH_W];
    assign bus.out_G      = out_pix_q[G_SLOT*CH_W +: CH_W];
    assign bus.out_B      = out_pix_q[B_SLOT*CH_W +: CH_W];
    assign bus.out_active = out_active_q;

    assign ovl = bus.pix_en & bus.active_area & opaque[COLL_A] & opaque[COLL_B];

    // frame_start is frame-timing, not pixel-timing, so it bypasses pix_en; a pixel
    // overlapping on the same cycle belongs to the new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            coll_count_q <= '0;
            coll_irq_q   <= 1'b0;
        end else begin
            coll_irq_q <= 1'b0;
            if (bus.frame_start) begin
                coll_count_q <= cnt_q;
                coll_irq_q   <= |cnt_q;
                cnt_q        <= CNT_W'(ovl);
            end else if (ovl && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.coll_count = coll_count_q;
    assign bus.coll_irq   = coll_irq_q;
endmodule
